uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver and successor to the fixed 8N1 receiver. It supports a programmable baud divisor, parameterised data width, optional even/odd parity and 1 or 2 stop bits. Received characters are reported with parity and framing error flags. It sits between the asynchronous RX pin and the RX async FIFO write side: `done` acts as the FIFO write strobe and {`frame_err`, `parity_err`, `data_out`} form the write word.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal 5..9), received LSB first.
DIV_W, 16, width of the runtime baud divisor `clk_per_bit`.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  asynchronous serial input, idle high.
clk_per_bit  input  DIV_W  clocks per bit; values below 4 are treated as 4.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
stop2  input  1  1 = two stop bits checked, 0 = one.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse, a character is complete.
data_out  output  DATA_BITS  received character, held until the next `done`.
parity_err  output  1  parity mismatch for the current `data_out`, held with it.
frame_err  output  1  a stop bit sampled low, held with `data_out`.
brk  output  1  one-cycle break pulse (see Optional Feature).

Behaviour:
- Reset (async, `rst_n`=0):
  - State IDLE; counters 0.
  - `done`, `busy`, `data_out`, `parity_err`, `frame_err` and `brk` all 0.
  - Both synchroniser flops set to 1.
- Input synchroniser: `rx` passes through a 2-flop synchroniser giving `rxs`. All decisions use `rxs` only.
- Config shadowing: `clk_per_bit` (after clamping), `parity_mode` and `stop2` are latched into shadow registers on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Bit counter: `cnt` is DIV_W bits wide, cleared at each state entry and at each bit sample. `D` denotes the shadowed divisor.
- States:
  - IDLE: if `rxs`==0 -> START (shadow config, `cnt`=0).
  - START: when `cnt`==D>>1, if `rxs`==0 -> DATA; otherwise -> IDLE (glitch rejected, no flags, no `done`).
  - DATA: when `cnt`==D-1, sample `rxs` into shift bit `idx`. After bit DATA_BITS-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: when `cnt`==D-1, sample the parity bit.
    - Even mode: error if XOR(data, parity bit) is 1.
    - Odd mode: error if XOR(data, parity bit) is 0.
  - STOP: when `cnt`==D-1, sample the stop bit; any low sample sets the frame error.
    - With `stop2`, a second stop sample follows D clocks later.
    - After the last stop sample, in the same clock edge:
      - load `data_out`, `parity_err` and `frame_err`;
      - pulse `done` for 1 cycle;
      - go to IDLE if the stop bit was good, else WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`==1, then -> IDLE. This prevents a low line after a framing error from being decoded as a new start bit.
- Sampling point: every sample is taken at mid-bit, because START ends at the half-bit point.
- Latency: `done` rises about (1 + DATA_BITS + P + S - 0.5)·D + 3 clocks after the `rx` falling edge, where P = 1 if parity is enabled (else 0) and S = stop bits.
- Back-to-back frames: after a good stop, IDLE detects a start edge on the very next cycle. There is no gap requirement.
- Width rules:
  - The internal parity calculation covers exactly DATA_BITS bits.
  - `idx` is wide enough for DATA_BITS-1.
  - `cnt` never exceeds D-1.
- Reset mid-frame: aborts immediately. No `done`; outputs return to reset values.

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- Defined: when the last stop sample is low, all data bits are 0 and any parity bit sampled is 0, `brk` pulses for 1 cycle together with `done`. `frame_err` is also set. The FSM then enters WAIT_IDLE and stays there until the line returns high.
- Undefined: `brk` is tied to 0 and no detection logic is generated. A break is reported only as `done` with `frame_err`=1 and `data_out`=0.

Test Plan:
1. 8N1, D=16, frame 0xA5 -> exactly one `done` pulse; `data_out`=0xA5, `parity_err`=0, `frame_err`=0; `done` lands 9.5 bit times (152 clk) ±3 clk after the falling edge.
2. Even parity, D=16, data 0x03 with parity bit 1 -> `done`, `data_out`=0x03, `parity_err`=1. Repeat with parity bit 0 -> `parity_err`=0. Odd mode with bit 1 -> `parity_err`=0.
3. 8N2, second stop bit driven low, data 0x5A -> `done`, `data_out`=0x5A, `frame_err`=1. No new frame starts until `rx` returns high.
4. `rx` low for 4 clk with D=16 -> `busy` rises and then falls; no `done`; all flags unchanged.
5. Start a frame with D=16, change `clk_per_bit` to 32 mid-frame -> frame decodes correctly at D=16. Assert `rst_n`=0 mid-data -> all outputs 0 immediately, and no `done` after release.
6. UART_RX_BREAK_DET_EN defined, `rx` low for 20 bit times -> a single `done` with `data_out`=0x00, `frame_err`=1, `brk`=1 for 1 cycle. The next 0x41 frame after the line goes high decodes cleanly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle for uart_rx_cfg: serial input, runtime configuration
// and the FIFO write-side outputs (done strobe plus error-tagged character).
interface uart_rx_cfg_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DIV_W     = 16
);
   logic                 rx;
   logic [DIV_W-1:0]     clk_per_bit;
   logic [1:0]           parity_mode;
   logic                 stop2;
   logic                 busy;
   logic                 done;
   logic [DATA_BITS-1:0] data_out;
   logic                 parity_err;
   logic                 frame_err;
   logic                 brk;

   // Receiver side: drives the FIFO write strobe and word
   modport master (
      input  rx, clk_per_bit, parity_mode, stop2,
      output busy, done, data_out, parity_err, frame_err, brk
   );

   // System side: drives the line and configuration, consumes characters
   modport slave (
      output rx, clk_per_bit, parity_mode, stop2,
      input  busy, done, data_out, parity_err, frame_err, brk
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: programmable divisor, DATA_BITS data
// bits LSB first, optional even/odd parity, one or two stop bits.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined;
// otherwise brk is tied low and a break appears only as a framing error.
module uart_rx_cfg #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DIV_W     = 16
) (
   input logic           clk,
   input logic           rst_n,
   uart_rx_cfg_if.master bus
);

   localparam int unsigned IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned MIN_DIV = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rxs;
   logic [DIV_W-1:0]     cnt;
   logic [DIV_W-1:0]     div_q;
   logic                 par_en_q;
   logic                 par_odd_q;
   logic                 stop2_q;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bit_q;
   logic                 stop_low_q;
   logic                 second_q;
   logic                 busy_q;
   logic                 done_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 perr_q;
   logic                 ferr_q;
`ifdef UART_RX_BREAK_DET_EN
   logic                 brk_q;
`endif

   logic [DIV_W-1:0]     div_clamp;
   logic                 half_hit;
   logic                 bit_hit;
   logic                 par_calc;

   // Divisor clamp and sample-point compares against the shadowed divisor
   always_comb begin
      div_clamp = (bus.clk_per_bit < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.clk_per_bit;
      half_hit  = (cnt == (div_q >> 1));
      bit_hit   = (cnt == (div_q - DIV_W'(1)));
      // Error when data plus parity bit does not have the selected sense
      par_calc  = par_en_q & ((^shift_q) ^ par_bit_q ^ par_odd_q);
   end

   // Two-flop synchroniser on the asynchronous line, idle high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rxs     <= rx_meta;
      end
   end

   // Receive FSM with bit timing, config shadowing and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         div_q      <= DIV_W'(MIN_DIV);
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
         idx        <= '0;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         stop_low_q <= 1'b0;
         second_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         brk_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         brk_q  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state      <= S_START;
                  cnt        <= '0;
                  div_q      <= div_clamp;
                  par_en_q   <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                  par_odd_q  <= (bus.parity_mode == 2'b10);
                  stop2_q    <= bus.stop2;
                  idx        <= '0;
                  par_bit_q  <= 1'b0;
                  stop_low_q <= 1'b0;
                  second_q   <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            S_START: begin
               if (half_hit) begin
                  cnt <= '0;
                  if (!rxs) begin
                     state <= S_DATA;
                  end else begin
                     // Start bit did not survive to mid-bit: treat as glitch
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end

            S_DATA: begin
               if (bit_hit) begin
                  cnt          <= '0;
                  shift_q[idx] <= rxs;
                  if (idx == IDX_W'(DATA_BITS - 1)) begin
                     idx   <= '0;
                     state <= par_en_q ? S_PARITY : S_STOP;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end

            S_PARITY: begin
               if (bit_hit) begin
                  cnt       <= '0;
                  par_bit_q <= rxs;
                  state     <= S_STOP;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end

            S_STOP: begin
               if (bit_hit) begin
                  cnt <= '0;
                  if (stop2_q && !second_q) begin
                     second_q   <= 1'b1;
                     stop_low_q <= ~rxs;
                  end else begin
                     done_q <= 1'b1;
                     data_q <= shift_q;
                     perr_q <= par_calc;
                     ferr_q <= stop_low_q | ~rxs;
`ifdef UART_RX_BREAK_DET_EN
                     brk_q  <= ~rxs && (shift_q == '0) && !(par_en_q && par_bit_q);
`endif
                     if (!rxs) begin
                        // Line still low: do not mistake it for a new start bit
                        state <= S_WAIT_IDLE;
                     end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end

            S_WAIT_IDLE: begin
               if (rxs) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state  <= S_IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.data_out   = data_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
`ifdef UART_RX_BREAK_DET_EN
   assign bus.brk        = brk_q;
`else
   assign bus.brk        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized
// frames compared against a bit-list reference model of the serial format.
module tb_uart_rx_cfg;

   localparam int unsigned DB  = 8;
   localparam int unsigned DW  = 16;
   localparam int          PER = 10;
`ifdef UART_RX_BREAK_DET_EN
   localparam logic BRK_EXP = 1'b1;
`else
   localparam logic BRK_EXP = 1'b0;
`endif

   typedef struct packed {
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
      logic          brk;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #(PER/2) clk = ~clk;

   uart_rx_cfg_if #(.DATA_BITS(DB), .DIV_W(DW)) bus ();
   uart_rx_cfg #(.DATA_BITS(DB), .DIV_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   rec_t        got_q[$];
   rec_t        exp_q[$];
   logic        tx_bits[$];
   rec_t        last_rec;
   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned brk_cnt = 0;
   time         done_time = 0;

   // Capture every done pulse and count brk pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) begin
            got_q.push_back({bus.data_out, bus.parity_err, bus.frame_err, bus.brk});
            done_time = $time - PER/2;
         end
         if (bus.brk) brk_cnt++;
      end
   end

   // Hard stop in case something never returns
   initial begin
      #(PER * 90000);
      $display("FAIL watchdog: simulation exceeded 90000 cycles");
      $fatal(1, "watchdog");
   end

   // Reference model: append one frame's line bits and its expected result
   task automatic push_frame(input logic [DB-1:0] data, input logic [1:0] pm,
                             input logic pbit, input logic s1, input logic s2,
                             input logic use_s2);
      rec_t r;
      int   ones;
      logic par_en;
      logic last_stop;
      ones   = 0;
      par_en = (pm == 2'b01) || (pm == 2'b10);
      tx_bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) begin
         tx_bits.push_back(data[i]);
         ones += int'(data[i]);
      end
      if (par_en) tx_bits.push_back(pbit);
      tx_bits.push_back(s1);
      if (use_s2) tx_bits.push_back(s2);
      last_stop = use_s2 ? s2 : s1;
      r.data = data;
      r.perr = par_en && (((ones + int'(pbit)) % 2) != ((pm == 2'b10) ? 1 : 0));
      r.ferr = !s1 || (use_s2 && !s2);
      r.brk  = BRK_EXP && !last_stop && (data == '0) && !(par_en && pbit);
      exp_q.push_back(r);
   endtask

   function automatic logic good_parity(input logic [DB-1:0] data, input logic [1:0] pm);
      int ones;
      ones = 0;
      for (int i = 0; i < DB; i++) ones += int'(data[i]);
      return ((ones % 2) == 1) ^ (pm == 2'b10);
   endfunction

   task automatic drive_bits(input int d);
      foreach (tx_bits[i]) begin
         bus.rx = tx_bits[i];
         repeat (d) @(negedge clk);
      end
      tx_bits.delete();
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input int cpb, input logic [1:0] pm, input logic st2);
      bus.clk_per_bit = DW'(cpb);
      bus.parity_mode = pm;
      bus.stop2       = st2;
   endtask

   task automatic test_reset;
      bus.rx = 1'b1;
      set_cfg(16, 2'b00, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.data_out, bus.parity_err, bus.frame_err, bus.brk} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b done=%b data=%h perr=%b ferr=%b brk=%b, expected all 0",
                  bus.busy, bus.done, bus.data_out, bus.parity_err, bus.frame_err, bus.brk);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_8n1;
      time t_fall;
      int  lat;
      rec_t g;
      set_cfg(16, 2'b00, 1'b0);
      push_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      t_fall = $time;
      drive_bits(16);
      idle(48);
      g = (got_q.size() > 0) ? got_q[0] : 'x;
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++;
         $display("FAIL 8n1_count got %0d done pulses, expected 1", got_q.size());
      end
      n_checks++;
      if (g !== exp_q[0]) begin
         n_fail++;
         $display("FAIL 8n1_word got %h, expected %h", g, exp_q[0]);
      end
      // 152 clocks +/-3 from the line edge, truncated to whole clocks
      lat = int'((done_time - t_fall) / PER);
      n_checks++;
      if (lat < 149 || lat > 155) begin
         n_fail++;
         $display("FAIL 8n1_latency got %0d clocks, expected 149..155", lat);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_parity;
      set_cfg(16, 2'b01, 1'b0);
      push_frame(8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
      drive_bits(16); idle(32);
      push_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
      drive_bits(16); idle(32);
      set_cfg(16, 2'b10, 1'b0);
      push_frame(8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
      drive_bits(16); idle(32);
      n_checks++;
      if (got_q.size() != 3) begin
         n_fail++;
         $display("FAIL parity_count got %0d done pulses, expected 3", got_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL parity_word%0d got %h, expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stop2;
      set_cfg(16, 2'b00, 1'b1);
      push_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
      drive_bits(16);
      // Line held low after the bad stop bit for three more bit times
      repeat (48) @(negedge clk);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL stop2_word got %0d pulses first %h, expected 1 pulse %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]);
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stop2_hold got busy=%b while line low, expected 1", bus.busy);
      end
      idle(40);
      n_checks++;
      if (bus.busy !== 1'b0 || got_q.size() != 1) begin
         n_fail++;
         $display("FAIL stop2_release got busy=%b pulses=%0d, expected 0 and 1",
                  bus.busy, got_q.size());
      end
      push_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
      drive_bits(16); idle(32);
      n_checks++;
      if (got_q.size() != 2 || got_q[1] !== exp_q[1]) begin
         n_fail++;
         $display("FAIL stop2_next got %0d pulses last %h, expected 2 pulses %h",
                  got_q.size(), (got_q.size() > 1) ? got_q[1] : 'x, exp_q[1]);
      end
      last_rec = exp_q[1];
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_glitch;
      logic seen;
      int   waited;
      set_cfg(16, 2'b00, 1'b0);
      seen   = 1'b0;
      waited = 0;
      bus.rx = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy) seen = 1'b1;
      end
      bus.rx = 1'b1;
      while ((bus.busy || !seen) && waited < 40) begin
         @(negedge clk);
         if (bus.busy) seen = 1'b1;
         waited++;
      end
      idle(32);
      n_checks++;
      if (seen !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy got seen=%b busy_end=%b, expected 1 0", seen, bus.busy);
      end
      n_checks++;
      if (got_q.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_done got %0d done pulses, expected 0", got_q.size());
      end
      n_checks++;
      if ({bus.data_out, bus.parity_err, bus.frame_err} !== {last_rec.data, last_rec.perr, last_rec.ferr}) begin
         n_fail++;
         $display("FAIL glitch_flags got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                  bus.data_out, bus.parity_err, bus.frame_err, last_rec.data, last_rec.perr, last_rec.ferr);
      end
      got_q.delete();
   endtask

   task automatic test_cfg_shadow;
      set_cfg(16, 2'b00, 1'b0);
      push_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      fork
         drive_bits(16);
         begin
            repeat (60) @(negedge clk);
            set_cfg(32, 2'b10, 1'b1);
         end
      join
      idle(40);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL shadow_word got %0d pulses first %h, expected 1 pulse %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]);
      end
      got_q.delete();
      exp_q.delete();
      set_cfg(16, 2'b00, 1'b0);
   endtask

   task automatic test_reset_mid;
      logic [7:0] pat;
      pat = 8'h96;
      set_cfg(16, 2'b00, 1'b0);
      bus.rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.rx = pat[i];
         repeat (16) @(negedge clk);
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_busy got busy=%b mid-frame, expected 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.data_out, bus.parity_err, bus.frame_err, bus.brk} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs got busy=%b data=%h perr=%b ferr=%b, expected all 0",
                  bus.busy, bus.data_out, bus.parity_err, bus.frame_err);
      end
      bus.rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      n_checks++;
      if (got_q.size() != 0 || bus.data_out !== '0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after got pulses=%0d data=%h busy=%b, expected 0 00 0",
                  got_q.size(), bus.data_out, bus.busy);
      end
      got_q.delete();
   endtask

   task automatic test_random;
      int         cpb_tab[6] = '{0, 3, 4, 5, 9, 16};
      int         cpb;
      int         d_eff;
      logic [1:0] pm;
      logic       st2;
      logic [7:0] data;
      logic       pbit;
      for (int n = 0; n < 40; n++) begin
         cpb   = cpb_tab[$urandom_range(0, 5)];
         d_eff = (cpb < 4) ? 4 : cpb;
         pm    = 2'($urandom_range(0, 3));
         st2   = 1'($urandom_range(0, 1));
         data  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) data = 8'h00;
         pbit  = good_parity(data, pm) ^ ($urandom_range(0, 3) == 0);
         set_cfg(cpb, pm, st2);
         push_frame(data, pm, pbit, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, st2);
         drive_bits(d_eff);
         idle(3 * d_eff + 8);
         n_checks++;
         if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL random%0d D=%0d pm=%b st2=%b got %0d pulses first %h, expected 1 pulse %h",
                     n, cpb, pm, st2, got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]);
         end
         got_q.delete();
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      set_cfg(16, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) push_frame(8'($urandom), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      drive_bits(16);
      idle(48);
      n_checks++;
      if (got_q.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_count got %0d done pulses, expected 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_word%0d got %h, expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_break;
      rec_t        exp_b;
      int unsigned brk0;
      exp_b = {8'h00, 1'b0, 1'b1, BRK_EXP};
      brk0  = brk_cnt;
      set_cfg(16, 2'b00, 1'b0);
      bus.rx = 1'b0;
      repeat (20 * 16) @(negedge clk);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_b) begin
         n_fail++;
         $display("FAIL break_word got %0d pulses first %h, expected 1 pulse %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_b);
      end
      n_checks++;
      if ((brk_cnt - brk0) != 32'(BRK_EXP) || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL break_pulse got brk_cycles=%0d busy=%b, expected %0d 1",
                  brk_cnt - brk0, bus.busy, BRK_EXP);
      end
      idle(40);
      got_q.delete();
      push_frame(8'h41, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      drive_bits(16); idle(32);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL break_next got %0d pulses first %h, expected 1 pulse %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      bus.rx = 1'b1;
      set_cfg(16, 2'b00, 1'b0);
      @(negedge clk);
      test_reset();
      test_8n1();
      test_parity();
      test_stop2();
      test_glitch();
      test_cfg_shadow();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_break();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
